// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM plus memory-mapped cycle counter,
// outbound mailbox FIFO and status register, all behind a zero-latency load path.
module dmem_responder #(
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;

  localparam logic [29:0] CYCLE_W  = 30'h2000_0000;
  localparam logic [29:0] MBOX_W   = 30'h2000_0001;
  localparam logic [29:0] STATUS_W = 30'h2000_0002;

  logic [31:0]   ram_r  [DEPTH];
  logic [31:0]   fifo_r [FIFO_DEPTH];
  logic [31:0]   cycle_r;
  logic [FW-1:0] rptr_r;
  logic [FW-1:0] wptr_r;
  logic [CW-1:0] count_r;
  logic [7:0]    drop_r;

  logic          is_ram_s;
  logic          is_cycle_s;
  logic          is_mbox_s;
  logic          is_status_s;
  logic [AW-1:0] ram_idx_s;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          accept_s;
  logic          drop_s;
  logic [31:0]   head_s;
  logic [31:0]   status_s;
  logic          unused_s;

  // Byte-lane bits never take part in decode.
  assign unused_s = ^aluout[1:0];

  assign is_ram_s    = ~aluout[31];
  assign is_cycle_s  = (aluout[31:2] == CYCLE_W);
  assign is_mbox_s   = (aluout[31:2] == MBOX_W);
  assign is_status_s = (aluout[31:2] == STATUS_W);
  assign ram_idx_s   = aluout[AW+1:2];

  assign empty_s  = (count_r == {CW{1'b0}});
  assign full_s   = (count_r == CW'(FIFO_DEPTH));
  assign push_s   = memwrite & is_mbox_s;
  assign pop_s    = ~empty_s & out_ready;
  // A pop frees the slot the same edge, so a full mailbox can still accept.
  assign accept_s = push_s & (~full_s | pop_s);
  assign drop_s   = push_s & full_s & ~pop_s;

  assign head_s    = empty_s ? 32'd0 : fifo_r[rptr_r];
  assign status_s  = {16'd0, drop_r, 6'(count_r), full_s, empty_s};
  assign out_valid = ~empty_s;
  assign out_data  = head_s;
  assign drop_cnt  = drop_r;

  // Load data mux, combinational for the single-cycle load path.
  always_comb begin
    readdata = 32'd0;
    if (is_ram_s) begin
      readdata = ram_r[ram_idx_s];
    end else if (is_cycle_s) begin
      readdata = cycle_r;
    end else if (is_mbox_s) begin
      readdata = head_s;
    end else if (is_status_s) begin
      readdata = status_s;
    end else begin
      readdata = 32'd0;
    end
  end

  // RAM store port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (memwrite && is_ram_s) begin
      ram_r[ram_idx_s] <= writedata;
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_r <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end

  // Mailbox storage; stale slots are masked by the empty flag.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      fifo_r[wptr_r] <= writedata;
    end
  end

  // Mailbox pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr_r  <= {FW{1'b0}};
      wptr_r  <= {FW{1'b0}};
      count_r <= {CW{1'b0}};
      drop_r  <= 8'd0;
    end else begin
      if (pop_s) begin
        rptr_r <= rptr_r + {{(FW-1){1'b0}}, 1'b1};
      end
      if (accept_s) begin
        wptr_r <= wptr_r + {{(FW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + {{(CW-1){1'b0}}, accept_s} - {{(CW-1){1'b0}}, pop_s};
      if (drop_s && (drop_r != 8'hFF)) begin
        drop_r <= drop_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: queue/array reference model checked
// every cycle, plus directed literal checks from the test plan.
module tb_dmem_responder;

  localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] A_MBOX   = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;
  localparam logic [31:0] A_UNMAP  = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] aluout = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic        out_ready = 1'b0;
  logic [31:0] readdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .readdata(readdata), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] ram_m [64];
  bit          ram_k [64];
  logic [31:0] mq [$];
  logic [31:0] cycle_m = 32'd0;
  int          drop_m = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = {16'd0, 8'(drop_m), 6'(mq.size()), 1'(mq.size() == 4), 1'(mq.size() == 0)};
    return s;
  endfunction

  // Model update at each rising edge
  always @(posedge clk) begin
    bit pop, push;
    if (memwrite && !aluout[31]) begin
      ram_m[aluout[7:2]] = writedata;
      ram_k[aluout[7:2]] = 1'b1;
    end
    if (reset) begin
      pop  = (mq.size() > 0) && out_ready;
      push = memwrite && (aluout[31:2] == A_MBOX[31:2]);
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < 4) mq.push_back(writedata);
        else if (drop_m < 255) drop_m++;
      end
      cycle_m = cycle_m + 32'd1;
    end
  end

  // Asynchronous reset clears the model immediately
  always @(negedge reset) begin
    mq.delete();
    cycle_m = 32'd0;
    drop_m  = 0;
  end

  // Per-cycle compare, just before the next rising edge
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    bit          have;
    #4;
    have = 1'b1;
    if (!aluout[31]) begin
      have   = ram_k[aluout[7:2]];
      exp_rd = ram_m[aluout[7:2]];
    end else if (aluout[31:2] == A_CYCLE[31:2]) exp_rd = cycle_m;
    else if (aluout[31:2] == A_MBOX[31:2]) exp_rd = (mq.size() > 0) ? mq[0] : 32'd0;
    else if (aluout[31:2] == A_STATUS[31:2]) exp_rd = m_status();
    else exp_rd = 32'd0;
    if (have) chk("model_readdata", readdata, exp_rd);
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("model_out_data", out_data, (mq.size() > 0) ? mq[0] : 32'd0);
    chk("model_drop_cnt", {24'd0, drop_cnt}, 32'(drop_m));
  end

  task automatic go(input logic mw, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    @(negedge clk);
    memwrite = mw; aluout = a; writedata = wd; out_ready = rdy;
    #1;
  endtask

  initial begin
    logic [31:0] c1, c3;
    for (int i = 0; i < 64; i++) ram_k[i] = 1'b0;

    // Reset and RAM
    aluout = A_STATUS;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_status", readdata, 32'h0000_0001);
    @(negedge clk);
    reset = 1'b1;
    go(1'b0, A_STATUS, 32'd0, 1'b0);
    chk("post_reset_status", readdata, 32'h0000_0001);
    chk("post_reset_valid", {31'd0, out_valid}, 32'd0);
    go(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    go(1'b0, 32'h0000_0010, 32'd0, 1'b0);
    chk("ram_load", readdata, 32'hDEAD_BEEF);
    go(1'b0, 32'h0000_0110, 32'd0, 1'b0);
    chk("ram_alias", readdata, 32'hDEAD_BEEF);

    // CYCLE
    go(1'b0, A_CYCLE, 32'd0, 1'b0);
    c1 = readdata;
    repeat (5) go(1'b0, A_CYCLE, 32'd0, 1'b0);
    chk("cycle_delta5", readdata - c1, 32'd5);
    go(1'b1, A_CYCLE, 32'h0000_1234, 1'b0);
    c3 = readdata;
    go(1'b0, A_CYCLE, 32'd0, 1'b0);
    chk("cycle_write_ignored", readdata - c3, 32'd1);

    // Fill, overflow, saturate
    for (int i = 1; i <= 6; i++) go(1'b1, A_MBOX, 32'(i), 1'b0);
    go(1'b0, A_STATUS, 32'd0, 1'b0);
    chk("fill_status", readdata, 32'h0000_0212);
    go(1'b0, A_MBOX, 32'd0, 1'b0);
    chk("mbox_head_read", readdata, 32'd1);
    repeat (300) go(1'b1, A_MBOX, 32'h0000_0BAD, 1'b0);
    go(1'b0, A_STATUS, 32'd0, 1'b0);
    chk("sat_status", readdata, 32'h0000_FF12);
    chk("sat_drop_cnt", {24'd0, drop_cnt}, 32'd255);

    // Drain with backpressure: ready 1,0,1,1,1
    go(1'b0, A_STATUS, 32'd0, 1'b1);
    chk("drain0", out_data, 32'd1);
    go(1'b0, A_STATUS, 32'd0, 1'b0);
    chk("drain1", out_data, 32'd2);
    go(1'b0, A_STATUS, 32'd0, 1'b1);
    chk("drain2_held", out_data, 32'd2);
    go(1'b0, A_STATUS, 32'd0, 1'b1);
    chk("drain3", out_data, 32'd3);
    go(1'b0, A_STATUS, 32'd0, 1'b1);
    chk("drain4", out_data, 32'd4);
    chk("drain4_valid", {31'd0, out_valid}, 32'd1);
    go(1'b0, A_STATUS, 32'd0, 1'b0);
    chk("drain_empty_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-operation with three entries queued
    for (int i = 0; i < 3; i++) go(1'b1, A_MBOX, 32'h50 + 32'(i), 1'b0);
    go(1'b0, A_STATUS, 32'd0, 1'b0);
    chk("three_queued", readdata, 32'h0000_FF0C);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("async_reset_status", readdata, 32'h0000_0001);
    #3 reset = 1'b1;

    // Unmapped access
    go(1'b0, A_UNMAP, 32'd0, 1'b0);
    chk("unmapped_read", readdata, 32'd0);
    go(1'b1, A_UNMAP, 32'h0000_FFFF, 1'b0);
    go(1'b0, A_STATUS, 32'd0, 1'b0);
    chk("unmapped_status", readdata, 32'h0000_0001);
    go(1'b0, 32'h0000_0010, 32'd0, 1'b0);
    chk("unmapped_ram", readdata, 32'hDEAD_BEEF);

    // Simultaneous push and pop at full
    for (int i = 0; i < 4; i++) go(1'b1, A_MBOX, 32'h12 + 32'(i), 1'b0);
    go(1'b1, A_MBOX, 32'h0000_00AA, 1'b1);
    chk("pushpop_head", out_data, 32'h12);
    go(1'b0, A_STATUS, 32'd0, 1'b0);
    chk("pushpop_status", readdata, 32'h0000_0012);
    go(1'b0, A_MBOX, 32'd0, 1'b1);
    chk("pp_drain0", readdata, 32'h13);
    go(1'b0, A_MBOX, 32'd0, 1'b1);
    chk("pp_drain1", out_data, 32'h14);
    go(1'b0, A_MBOX, 32'd0, 1'b1);
    chk("pp_drain2", out_data, 32'h15);
    go(1'b0, A_MBOX, 32'd0, 1'b1);
    chk("pp_last_aa", out_data, 32'hAA);
    go(1'b0, A_MBOX, 32'd0, 1'b0);
    chk("pp_empty", {31'd0, out_valid}, 32'd0);

    // Empty mailbox: push with ready high is accepted, not popped
    go(1'b1, A_MBOX, 32'h77, 1'b1);
    go(1'b0, A_STATUS, 32'd0, 1'b0);
    chk("empty_pushpop", readdata, 32'h0000_0004);

    go(1'b0, A_STATUS, 32'd0, 1'b0);
    #10;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
